// File: rtl/fir_pkg.sv
// Shared constants, state encoding and circular-index helper for the FIR operand feeder
// and the MAC-side collector.
package fir_pkg;

    localparam int NTAP = 11;
    localparam int DW   = 32;
    localparam int AW   = 4;

    localparam logic [AW-1:0] NTAP_A = AW'(NTAP);
    localparam logic [AW-1:0] LAST_K = AW'(NTAP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_e;

    // (base - k) mod NTAP without assuming NTAP is a power of two.
    // The intermediate sum may overflow AW bits, but the final value is < NTAP.
    function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] base,
                                               input logic [AW-1:0] k);
        logic [AW-1:0] r;
        if (base >= k) r = base - k;
        else           r = base + NTAP_A - k;
        return r;
    endfunction

endpackage

// File: rtl/fir_circ_buf.sv
// NTAP-deep sample history: one write port, one wrapped read port (base - k),
// and a single-cycle synchronous clear.
module fir_circ_buf
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          clear,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] k,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [NTAP];
    logic [DW-1:0] mem_d [NTAP];

    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            for (int i = 0; i < NTAP; i++) mem_d[i] = '0;
        end else if (we && (waddr < NTAP_A)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[wrap_sub(base, k)];

endmodule

// File: rtl/fir_operand_feeder.sv
// Feeds NTAP (X, tap) pairs per accepted sample to the MAC, newest sample first.
// Output registers run one pair ahead of k so pair 0 is visible the cycle after acceptance.
module fir_operand_feeder
    import fir_pkg::*;
(
    input  logic          CLK,
    input  logic          Reset,
    input  logic          tap_we,
    input  logic [AW-1:0] tap_addr,
    input  logic [DW-1:0] tap_wdata,
    output logic          tap_wr_err,
    input  logic          clear,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    input  logic          ss_tlast,
    output logic          ss_tready,
    output logic [DW-1:0] X,
    output logic [DW-1:0] tap,
    output logic          mac_valid,
    output logic          mac_first,
    output logic          mac_last,
    output logic          mac_tlast,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] k_q, k_d;
    logic          tlast_q, tlast_d;
    logic [DW-1:0] taps_q [NTAP];
    logic [DW-1:0] taps_d [NTAP];

    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] tap_q, tap_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          mtlast_q, mtlast_d;
    logic          wr_err_q, wr_err_d;

    logic          accept;
    logic          buf_clear;
    logic          tap_ok;
    logic [AW-1:0] k_next;
    logic [DW-1:0] buf_rdata;

    assign ss_tready = !Reset && (state_q == IDLE) && !clear;
    assign accept    = ss_tvalid && ss_tready;
    assign buf_clear = (state_q == IDLE) && clear;
    assign tap_ok    = tap_we && (state_q == IDLE) && (tap_addr < NTAP_A);
    assign k_next    = k_q + AW'(1);

    fir_circ_buf u_buf (
        .clk   (CLK),
        .rst   (Reset),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (ss_tdata),
        .clear (buf_clear),
        .base  (base_q),
        .k     (k_next),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        k_d      = k_q;
        tlast_d  = tlast_q;
        taps_d   = taps_q;
        x_d      = '0;
        tap_d    = '0;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        mtlast_d = 1'b0;
        wr_err_d = tap_we && ((state_q == FEED) || (tap_addr >= NTAP_A));

        if (tap_ok) taps_d[tap_addr] = tap_wdata;

        case (state_q)
            IDLE: begin
                if (buf_clear) begin
                    wr_ptr_d = '0;
                end else if (accept) begin
                    state_d  = FEED;
                    base_d   = wr_ptr_q;
                    tlast_d  = ss_tlast;
                    k_d      = '0;
                    // Pair 0 bypasses the buffer and picks up a same-cycle tap write.
                    x_d      = ss_tdata;
                    tap_d    = taps_d[0];
                    valid_d  = 1'b1;
                    first_d  = 1'b1;
                    last_d   = (LAST_K == '0);
                    mtlast_d = ss_tlast && (LAST_K == '0);
                end
            end
            FEED: begin
                if (k_q == LAST_K) begin
                    state_d  = IDLE;
                    wr_ptr_d = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + AW'(1);
                end else begin
                    k_d      = k_next;
                    x_d      = buf_rdata;
                    tap_d    = taps_q[k_next];
                    valid_d  = 1'b1;
                    last_d   = (k_next == LAST_K);
                    mtlast_d = tlast_q && (k_next == LAST_K);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            base_q   <= '0;
            k_q      <= '0;
            tlast_q  <= 1'b0;
            for (int i = 0; i < NTAP; i++) taps_q[i] <= '0;
            x_q      <= '0;
            tap_q    <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            mtlast_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            k_q      <= k_d;
            tlast_q  <= tlast_d;
            taps_q   <= taps_d;
            x_q      <= x_d;
            tap_q    <= tap_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            mtlast_q <= mtlast_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign X          = x_q;
    assign tap        = tap_q;
    assign mac_valid  = valid_q;
    assign mac_first  = first_q;
    assign mac_last   = last_q;
    assign mac_tlast  = mtlast_q;
    assign tap_wr_err = wr_err_q;
    assign busy       = (state_q == FEED);

endmodule

// File: tb/tb_fir_operand_feeder.sv
// Bench for fir_operand_feeder: directed scenarios plus random traffic against a
// sample-history / tap-array reference model.
module tb_fir_operand_feeder;
    import fir_pkg::*;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          tap_we = 1'b0;
    logic [AW-1:0] tap_addr = '0;
    logic [DW-1:0] tap_wdata = '0;
    logic          tap_wr_err;
    logic          clear = 1'b0;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic [DW-1:0] X, tap;
    logic          mac_valid, mac_first, mac_last, mac_tlast, busy;

    fir_operand_feeder dut (
        .CLK(CLK), .Reset(Reset),
        .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata), .tap_wr_err(tap_wr_err),
        .clear(clear), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .ss_tready(ss_tready), .X(X), .tap(tap), .mac_valid(mac_valid),
        .mac_first(mac_first), .mac_last(mac_last), .mac_tlast(mac_tlast), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: newest-first sample history and the tap array.
    logic [DW-1:0] hist[$];
    logic [DW-1:0] taps_m [NTAP];
    int  last_acc = 0;
    bit  prev_keep = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tap_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tap_we = 1'b1; tap_addr = a; tap_wdata = d;
        step();
        tap_we = 1'b0;
        chk("wr_err_idle", tap_wr_err, a >= NTAP);
        if (a < NTAP) taps_m[a] = d;
    endtask

    task automatic do_clear(input bit with_valid);
        clear = 1'b1; ss_tvalid = with_valid; ss_tdata = 32'hdead_beef;
        #1;
        chk("tready_clr", ss_tready, 0);
        step();
        clear = 1'b0; ss_tvalid = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_valid", mac_valid, 0);
        hist.delete();
    endtask

    // Offer one sample (optionally with a same-cycle tap write), then check all NTAP pairs.
    // bad_at: pair index at which a rejected tap write (and optionally clear) is driven.
    task automatic feed(input logic [DW-1:0] d, input logic tl, input bit keep,
                        input bit tw, input logic [AW-1:0] ta, input logic [DW-1:0] td,
                        input int bad_at, input logic [AW-1:0] bad_addr, input bit clr_mid);
        logic [DW-1:0] xe [NTAP];
        logic [DW-1:0] te [NTAP];
        bit err_exp;
        int t_acc;
        ss_tdata = d; ss_tlast = tl; ss_tvalid = 1'b1;
        tap_we = tw; tap_addr = ta; tap_wdata = td;
        #1;
        chk("tready_pre", ss_tready, 1);
        if (tw && ta < NTAP) taps_m[ta] = td;
        hist.push_front(d);
        if (hist.size() > NTAP) void'(hist.pop_back());
        for (int k = 0; k < NTAP; k++) begin
            xe[k] = (k < hist.size()) ? hist[k] : '0;
            te[k] = taps_m[k];
        end
        t_acc = cyc;
        if (prev_keep) chk("b2b_gap", t_acc - last_acc, NTAP + 1);
        last_acc = t_acc;
        prev_keep = keep;
        step();
        if (!keep) ss_tvalid = 1'b0;
        tap_we = 1'b0;
        err_exp = tw && (ta >= NTAP);
        for (int k = 0; k < NTAP; k++) begin
            chk("valid", mac_valid, 1);
            chk("busy", busy, 1);
            chk("tready_feed", ss_tready, 0);
            chk("X", X, xe[k]);
            chk("tap", tap, te[k]);
            chk("first", mac_first, k == 0);
            chk("last", mac_last, k == NTAP - 1);
            chk("tlast", mac_tlast, tl && (k == NTAP - 1));
            chk("wr_err_feed", tap_wr_err, err_exp);
            err_exp = 0;
            if (k == bad_at && k < NTAP - 1) begin
                tap_we = 1'b1; tap_addr = bad_addr; tap_wdata = 32'd99;
                clear = clr_mid;
            end
            step();
            if (k == bad_at && k < NTAP - 1) err_exp = 1;
            tap_we = 1'b0; clear = 1'b0;
        end
        chk("post_valid", mac_valid, 0);
        chk("post_X", X, 0);
        chk("post_tap", tap, 0);
        chk("post_last", mac_last, 0);
        chk("post_busy", busy, 0);
        chk("post_tready", ss_tready, 1);
    endtask

    task automatic feed_simple(input logic [DW-1:0] d);
        feed(d, 1'b0, 1'b0, 1'b0, '0, '0, -1, '0, 1'b0);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NTAP; i++) taps_m[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", mac_valid, 0);
        chk("rst_X", X, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", tap_wr_err, 0);
        Reset = 1'b0;
        #1;
        chk("rst_tready", ss_tready, 1);
        step();

        // Impulse with taps 1..11
        for (int i = 0; i < NTAP; i++) tap_write(AW'(i), 32'(i + 1));
        feed_simple(32'd1);
        feed_simple(32'd0);
        feed_simple(32'd0);

        // Wrap-around: taps all 1, samples 1..12
        for (int i = 0; i < NTAP; i++) tap_write(AW'(i), 32'd1);
        do_clear(1'b0);
        for (int s = 1; s <= 12; s++) feed_simple(32'(s));

        // Back-to-back, ss_tlast on the third
        feed(32'h11, 1'b0, 1'b1, 1'b0, '0, '0, -1, '0, 1'b0);
        feed(32'h22, 1'b0, 1'b1, 1'b0, '0, '0, -1, '0, 1'b0);
        feed(32'h33, 1'b1, 1'b0, 1'b0, '0, '0, -1, '0, 1'b0);

        // Tap write during FEED rejected (with a clear that must be ignored), then in IDLE
        feed(32'h44, 1'b0, 1'b0, 1'b0, '0, '0, 5, '0, 1'b1);
        tap_write('0, 32'd99);
        feed_simple(32'h55);
        tap_write(4'd12, 32'd7);
        feed(32'h66, 1'b0, 1'b0, 1'b1, 4'd3, 32'd1234, -1, '0, 1'b0);

        // clear + ss_tvalid together with history 5,6,7
        feed_simple(32'd5); feed_simple(32'd6); feed_simple(32'd7);
        do_clear(1'b1);
        feed_simple(32'd3);

        // Reset during pair 4 of a feed
        ss_tdata = 32'h77; ss_tvalid = 1'b1;
        step();
        ss_tvalid = 1'b0;
        repeat (4) step();
        chk("abort_pre_valid", mac_valid, 1);
        Reset = 1'b1;
        #1;
        chk("abort_valid", mac_valid, 0);
        chk("abort_X", X, 0);
        chk("abort_tap", tap, 0);
        chk("abort_busy", busy, 0);
        step();
        Reset = 1'b0;
        #1;
        chk("abort_tready", ss_tready, 1);
        model_reset();
        prev_keep = 0;
        step();
        for (int i = 0; i < NTAP; i++) tap_write(AW'(i), 32'(i + 3));
        feed_simple(32'h88);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                feed($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 15),
                     AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else if (op <= 7) begin
                tap_write(AW'($urandom_range(0, 15)), $urandom);
            end else if (op == 8) begin
                do_clear(1'($urandom_range(0, 1)));
            end else begin
                step();
                chk("idle_valid", mac_valid, 0);
                chk("idle_X", X, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
